// File: rtl/tetris_pkg.sv
// Shared definitions for the piece-generation path: default piece geometry
// and the all-ones "no piece" code.
package tetris_pkg;

  localparam int DEFAULT_PIECE_W   = 3;
  localparam int DEFAULT_NUM_TYPES = 7;

  typedef logic [DEFAULT_PIECE_W-1:0] piece_t;

  localparam piece_t PIECE_NONE = '1;

endpackage

// File: rtl/piece_fifo.sv
// Circular piece buffer with head/tail pointers, an occupancy counter and
// PREVIEW read taps starting at the head; empty taps read all-ones.
module piece_fifo #(
  parameter int DEPTH   = 8,
  parameter int PREVIEW = 5,
  parameter int PIECE_W = 3,
  localparam int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       clear,
  input  logic                       push,
  input  logic [PIECE_W-1:0]         push_data,
  input  logic                       pop,
  output logic [PIECE_W-1:0]         head,
  output logic [PREVIEW*PIECE_W-1:0] preview,
  output logic [LVL_W-1:0]           level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   DEPTH_X  = (PTR_W + 1)'(DEPTH);

  logic [PIECE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   head_ptr, tail_ptr;
  logic [PTR_W:0]     tap_idx;

  // Wrap is an explicit compare so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // NOTE: storage is deliberately not reset; slots at or beyond level are
  // masked to all-ones on every read path, so stale contents never escape.
  always_ff @(posedge clk) begin
    if (push) mem[tail_ptr] <= push_data;
  end

  // NOTE: every register here uses <= so all updates see pre-edge values.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      level    <= '0;
    end else if (clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      level    <= '0;
    end else begin
      if (push) tail_ptr <= ptr_inc(tail_ptr);
      if (pop)  head_ptr <= ptr_inc(head_ptr);
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  // NOTE: outputs get a full default before the loop so no latch is inferred.
  always_comb begin
    preview = '1;
    tap_idx = '0;
    for (int i = 0; i < PREVIEW; i++) begin
      tap_idx = {1'b0, head_ptr} + (PTR_W + 1)'(i);
      if (tap_idx >= DEPTH_X) tap_idx = tap_idx - DEPTH_X;
      if (LVL_W'(i) < level) preview[i*PIECE_W +: PIECE_W] = mem[tap_idx[PTR_W-1:0]];
    end
  end

  assign head = preview[PIECE_W-1:0];

endmodule

// File: rtl/piece_bag_queue.sv
// Bag filter in front of a preview FIFO: accepts each piece type COPIES times
// per bag from a free-running candidate stream and refills bags on its own.
module piece_bag_queue
  import tetris_pkg::*;
#(
  parameter int NUM_TYPES = DEFAULT_NUM_TYPES,
  parameter int PIECE_W   = DEFAULT_PIECE_W,
  parameter int COPIES    = 1,
  parameter int DEPTH     = 8,
  parameter int PREVIEW   = 5,
  localparam int LVL_W    = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       clear,
  input  logic                       cand_valid,
  input  logic [PIECE_W-1:0]         cand,
  output logic                       cand_accept,
  output logic                       pop_valid,
  input  logic                       pop_ready,
  output logic [PIECE_W-1:0]         pop_piece,
  output logic [PREVIEW*PIECE_W-1:0] preview,
  output logic [LVL_W-1:0]           level,
  output logic                       bag_done
);

  localparam int CNT_W    = $clog2(COPIES + 1);
  localparam int BAG_SIZE = NUM_TYPES * COPIES;
  localparam int TOT_W    = $clog2(BAG_SIZE + 1);

  localparam logic [CNT_W-1:0] COPIES_L = CNT_W'(COPIES);
  localparam logic [TOT_W-1:0] BAG_LAST = TOT_W'(BAG_SIZE - 1);
  localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(DEPTH);

  logic [CNT_W-1:0] taken [NUM_TYPES];
  logic [TOT_W-1:0] bag_total;
  logic             in_range, type_open, has_room, pop_fire, bag_full;

  // A code matches some type exactly when it is legal, so the match loop
  // doubles as the range check and never indexes taken[] out of bounds.
  always_comb begin
    in_range  = 1'b0;
    type_open = 1'b0;
    for (int t = 0; t < NUM_TYPES; t++) begin
      if (cand == PIECE_W'(t)) begin
        in_range  = 1'b1;
        type_open = taken[t] < COPIES_L;
      end
    end
  end

  assign pop_valid   = level != '0;
  assign pop_fire    = pop_valid & pop_ready & ~clear;
  assign has_room    = (level < DEPTH_L) | pop_fire;
  assign cand_accept = cand_valid & in_range & type_open & nreset & ~clear & has_room;
  assign bag_full    = cand_accept & (bag_total == BAG_LAST);

  // The completing accept restarts the bag on the same edge, so the very
  // next candidate already counts toward the new bag.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int t = 0; t < NUM_TYPES; t++) taken[t] <= '0;
      bag_total <= '0;
      bag_done  <= 1'b0;
    end else begin
      bag_done <= bag_full;
      if (clear || bag_full) begin
        for (int t = 0; t < NUM_TYPES; t++) taken[t] <= '0;
        bag_total <= '0;
      end else if (cand_accept) begin
        for (int t = 0; t < NUM_TYPES; t++) begin
          if (cand == PIECE_W'(t)) taken[t] <= taken[t] + 1'b1;
        end
        bag_total <= bag_total + 1'b1;
      end
    end
  end

  piece_fifo #(
    .DEPTH   (DEPTH),
    .PREVIEW (PREVIEW),
    .PIECE_W (PIECE_W)
  ) u_fifo (
    .clk       (clk),
    .nreset    (nreset),
    .clear     (clear),
    .push      (cand_accept),
    .push_data (cand),
    .pop       (pop_fire),
    .head      (pop_piece),
    .preview   (preview),
    .level     (level)
  );

endmodule

// File: tb/tb_piece_bag_queue.sv
// Bench for piece_bag_queue: a default instance and a 14-bag instance with a
// non-power-of-two FIFO, both compared every cycle against a queue model.
module tb_piece_bag_queue;
  import tetris_pkg::*;

  localparam int NT = 7;
  localparam int PW = 3;
  localparam int PV = 5;

  logic clk = 1'b0;
  logic nreset, clear, cand_valid, pop_ready;
  logic [PW-1:0] cand;

  logic acc0, pv0, bd0;
  logic [PW-1:0] pp0;
  logic [PV*PW-1:0] prev0;
  logic [3:0] lvl0;

  logic acc1, pv1, bd1;
  logic [PW-1:0] pp1;
  logic [PV*PW-1:0] prev1;
  logic [2:0] lvl1;

  piece_bag_queue dut0 (
    .clk(clk), .nreset(nreset), .clear(clear), .cand_valid(cand_valid), .cand(cand),
    .cand_accept(acc0), .pop_valid(pv0), .pop_ready(pop_ready), .pop_piece(pp0),
    .preview(prev0), .level(lvl0), .bag_done(bd0)
  );

  piece_bag_queue #(.COPIES(2), .DEPTH(6), .PREVIEW(PV)) dut1 (
    .clk(clk), .nreset(nreset), .clear(clear), .cand_valid(cand_valid), .cand(cand),
    .cand_accept(acc1), .pop_valid(pv1), .pop_ready(pop_ready), .pop_piece(pp1),
    .preview(prev1), .level(lvl1), .bag_done(bd1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model: a plain queue plus per-type counts ----
  piece_t none_code;
  int mq [2][$];
  int mt [2][NT];
  int mtot [2];
  bit mbd [2];

  function automatic int copies_of(int k); return (k == 0) ? 1 : 2; endfunction
  function automatic int depth_of(int k);  return (k == 0) ? 8 : 6; endfunction

  function automatic bit m_pop(int k);
    return (mq[k].size() > 0) && pop_ready && !clear;
  endfunction

  function automatic bit m_accept(int k);
    if (!nreset || clear || !cand_valid || int'(cand) >= NT) return 1'b0;
    if (mt[k][cand] >= copies_of(k)) return 1'b0;
    return (mq[k].size() < depth_of(k)) || m_pop(k);
  endfunction

  function automatic void m_clear(int k);
    mq[k].delete();
    for (int t = 0; t < NT; t++) mt[k][t] = 0;
    mtot[k] = 0;
    mbd[k]  = 1'b0;
  endfunction

  function automatic void m_update(int k);
    bit a = m_accept(k);
    bit p = m_pop(k);
    if (clear) begin
      m_clear(k);
      return;
    end
    mbd[k] = 1'b0;
    if (p) void'(mq[k].pop_front());
    if (a) begin
      mq[k].push_back(int'(cand));
      mt[k][cand]++;
      mtot[k]++;
      if (mtot[k] == NT * copies_of(k)) begin
        for (int t = 0; t < NT; t++) mt[k][t] = 0;
        mtot[k] = 0;
        mbd[k]  = 1'b1;
      end
    end
  endfunction

  function automatic int exp_slot(int k, int i);
    return (i < mq[k].size()) ? mq[k][i] : int'(none_code);
  endfunction

  task automatic model_check(input int k);
    int a, l, v, h, b, p, e;
    if (k == 0) begin a = acc0; l = lvl0; v = pv0; h = pp0; b = bd0; p = prev0; end
    else        begin a = acc1; l = lvl1; v = pv1; h = pp1; b = bd1; p = prev1; end
    e = 0;
    for (int i = 0; i < PV; i++) e |= exp_slot(k, i) << (PW * i);
    check($sformatf("m%0d.cand_accept", k), a, m_accept(k));
    check($sformatf("m%0d.level", k), l, mq[k].size());
    check($sformatf("m%0d.pop_valid", k), v, mq[k].size() > 0);
    check($sformatf("m%0d.pop_piece", k), h, exp_slot(k, 0));
    check($sformatf("m%0d.preview", k), p, e);
    check($sformatf("m%0d.bag_done", k), b, mbd[k]);
  endtask

  // ---------------- cycle driver -------------------------------------------
  int s_acc, s_lvl, s_head, s_pv, s_bd;
  int acc1_cnt, bd1_cnt;

  task automatic step(input bit c, input bit v, input int d, input bit r);
    clear = c; cand_valid = v; cand = PW'(d); pop_ready = r;
    @(negedge clk);
    model_check(0);
    model_check(1);
    s_acc = acc0; s_lvl = lvl0; s_head = pp0; s_pv = pv0; s_bd = bd0;
    acc1_cnt += acc1;
    bd1_cnt  += bd1;
    m_update(0);
    m_update(1);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit clr; bit cv; int cd; bit pr;
    bit acc; int lvl; int head; bit bd;
  } vec_t;

  vec_t vt[$];

  task automatic add(input bit c, input bit v, input int d, input bit r,
                     input bit a, input int l, input int h, input bit b);
    vec_t x;
    x.clr = c; x.cv = v; x.cd = d; x.pr = r;
    x.acc = a; x.lvl = l; x.head = h; x.bd = b;
    vt.push_back(x);
  endtask

  task automatic run_vectors(input string tag);
    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].clr, vt[i].cv, vt[i].cd, vt[i].pr);
      check($sformatf("%s[%0d].accept", tag, i), s_acc, vt[i].acc);
      check($sformatf("%s[%0d].level", tag, i), s_lvl, vt[i].lvl);
      check($sformatf("%s[%0d].head", tag, i), s_head, vt[i].head);
      check($sformatf("%s[%0d].pop_valid", tag, i), s_pv, vt[i].lvl != 0);
      check($sformatf("%s[%0d].bag_done", tag, i), s_bd, vt[i].bd);
    end
    vt.delete();
  endtask

  function automatic int pack5(input int a, input int b, input int c, input int d, input int e);
    return a | (b << 3) | (c << 6) | (d << 9) | (e << 12);
  endfunction

  initial begin
    none_code = PIECE_NONE;
    m_clear(0);
    m_clear(1);
    acc1_cnt = 0;
    bd1_cnt  = 0;

    // Reset state, with a legal candidate offered while held in reset.
    nreset = 1'b0; clear = 1'b0; cand_valid = 1'b1; cand = 3'd2; pop_ready = 1'b1;
    #12;
    check("rst.accept0", acc0, 0);
    check("rst.accept1", acc1, 0);
    check("rst.level", lvl0, 0);
    check("rst.pop_valid", pv0, 0);
    check("rst.pop_piece", pp0, 7);
    check("rst.preview", prev0, 32'h7fff);
    check("rst.bag_done", bd0, 0);
    cand_valid = 1'b0;
    @(posedge clk);
    #1;
    nreset = 1'b1;

    // Full 7-bag back-to-back, no pops.
    add(0,1,0,0, 1,0,7,0); add(0,1,1,0, 1,1,0,0); add(0,1,2,0, 1,2,0,0);
    add(0,1,3,0, 1,3,0,0); add(0,1,4,0, 1,4,0,0); add(0,1,5,0, 1,5,0,0);
    add(0,1,6,0, 1,6,0,0); add(0,0,0,0, 0,7,0,1); add(0,0,0,0, 0,7,0,0);
    run_vectors("bag7");
    check("bag7.preview", prev0, pack5(0, 1, 2, 3, 4));

    // Duplicate and out-of-range codes are dropped.
    add(1,1,0,0, 0,7,0,0); add(0,1,3,0, 1,0,7,0); add(0,1,3,0, 0,1,3,0);
    add(0,1,7,0, 0,1,3,0); add(0,1,5,0, 1,1,3,0); add(0,0,0,0, 0,2,3,0);
    run_vectors("dup");

    // Fill to 8 across a bag boundary, then push and pop together at full.
    add(0,1,0,0, 1,2,3,0); add(0,1,1,0, 1,3,3,0); add(0,1,2,0, 1,4,3,0);
    add(0,1,4,0, 1,5,3,0); add(0,1,6,0, 1,6,3,0); add(0,1,0,0, 1,7,3,1);
    add(0,1,1,0, 0,8,3,0); add(0,1,2,1, 1,8,3,0); add(0,0,0,0, 0,8,5,0);
    run_vectors("full");
    check("full.preview", prev0, pack5(5, 0, 1, 2, 4));

    // Empty FIFO: accepted piece is visible next cycle, then popped away.
    add(1,0,0,0, 0,8,5,0); add(0,1,4,0, 1,0,7,0); add(0,0,0,1, 0,1,4,0);
    add(0,0,0,0, 0,0,7,0);
    run_vectors("empty");

    // clear mid-bag: no bag_done, and the same codes are accepted again.
    add(0,1,0,0, 1,0,7,0); add(0,1,1,0, 1,1,0,0); add(0,1,2,0, 1,2,0,0);
    add(1,1,3,0, 0,3,0,0); add(0,1,0,0, 1,0,7,0); add(0,1,1,0, 1,1,0,0);
    add(0,1,2,0, 1,2,0,0); add(0,0,0,0, 0,3,0,0);
    run_vectors("clr");

    // COPIES=2 instance: three 0s yield two accepts; bag_done only after 14.
    step(1, 0, 0, 0);
    acc1_cnt = 0;
    bd1_cnt  = 0;
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1);
    check("bag14.zero_accepts", acc1_cnt, 2);
    for (int t = 1; t < NT; t++) begin
      step(0, 1, t, 1);
      step(0, 1, t, 1);
    end
    check("bag14.accepts", acc1_cnt, 14);
    check("bag14.no_early_done", bd1_cnt, 0);
    step(0, 0, 0, 1);
    check("bag14.done_once", bd1_cnt, 1);

    // Asynchronous reset in the middle of a bag drops all history at once.
    step(1, 0, 0, 0);
    step(0, 1, 1, 0);
    step(0, 1, 2, 0);
    step(0, 1, 3, 0);
    cand_valid = 1'b1; cand = 3'd4; pop_ready = 1'b0;
    #2;
    nreset = 1'b0;
    #1;
    check("arst.accept", acc0, 0);
    check("arst.level", lvl0, 0);
    check("arst.pop_piece", pp0, 7);
    check("arst.preview", prev0, 32'h7fff);
    check("arst.level1", lvl1, 0);
    m_clear(0);
    m_clear(1);
    cand_valid = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;
    step(0, 1, 1, 0);
    check("arst.reaccept", s_acc, 1);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/piece_bag_queue.md
# piece_bag_queue

Parametrised successor to the single-shot 7-bag collector. Filters a free-running random candidate stream into bags. Each bag holds every piece type exactly COPIES times. Accepted pieces are buffered in a FIFO that the game controller drains one piece at a time, while the next PREVIEW pieces stay visible. Bags refill automatically with no external `newbag` strobe, so the block sits between the LFSR and the piece-spawn logic in the controller.

## Interface
- NUM_TYPES, default 7: number of piece types; legal piece codes are 0..NUM_TYPES-1.
- PIECE_W, default 3: piece code width; 2**PIECE_W > NUM_TYPES is required.
- COPIES, default 1: copies of each type per bag (1 = 7-bag, 2 = 14-bag).
- DEPTH, default 8: FIFO entries, >= 2.
- PREVIEW, default 5: preview taps, 1 <= PREVIEW <= DEPTH.
- clk  in  1  clock.
- nreset  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous flush of FIFO and bag state.
- cand_valid  in  1  candidate present this cycle.
- cand  in  PIECE_W  candidate piece code.
- cand_accept  out  1  combinational; candidate taken this cycle.
- pop_valid  out  1  FIFO non-empty.
- pop_ready  in  1  consumer takes head this cycle.
- pop_piece  out  PIECE_W  head entry; all-ones when empty.
- preview  out  PREVIEW*PIECE_W  slot i in bits [i*PIECE_W +: PIECE_W]; slot 0 = head.
- level  out  $clog2(DEPTH+1)  FIFO occupancy.
- bag_done  out  1  one-cycle pulse when a bag completes.

## Operation
- Per-type counters taken[t] have width $clog2(COPIES+1). A bag total counter has width $clog2(NUM_TYPES*COPIES+1).
- cand_accept is asserted when all of these hold:
  - cand_valid is high.
  - cand < NUM_TYPES.
  - taken[cand] < COPIES.
  - nreset is high and clear is low.
  - The FIFO has room: level < DEPTH, or a pop happens in the same cycle.
- Any candidate not accepted is dropped silently; there is no backpressure on the source.
- On accept, cand is written at the tail, taken[cand] increments, and the bag total increments.
- When an accept brings the bag total to NUM_TYPES*COPIES:
  - All taken[] and the bag total go to 0 on the same clock edge.
  - bag_done pulses in the following cycle.
  - The next cycle's candidates count toward the new bag.
- A pop occurs when pop_valid and pop_ready are both high. It advances the head and does not affect bag state.
- Push and pop in the same cycle leave level unchanged. This works at full (new tail, old head gone) and at level 1.
- preview slot i shows the entry i positions behind the head when i < level, and all-ones otherwise.
- clear overrides accept and pop for that cycle:
  - Empties the FIFO.
  - Zeroes all taken[] and the bag total.
  - Suppresses bag_done.

## Timing
- Reset values:
  - level = 0, pop_valid = 0, bag_done = 0.
  - pop_piece = all-ones, every preview slot = all-ones.
  - cand_accept = 0 while nreset is low.
- Accept-to-visible latency is 1 cycle. A piece accepted at edge N appears on pop_piece, preview and level after edge N; this also holds when the FIFO was empty.
- Pop-to-update latency is 1 cycle. The head advances at the edge where the pop is sampled.
- Maximum fill rate is one piece per cycle. A full bag needs at least NUM_TYPES*COPIES cycles.
- An nreset assertion mid-bag immediately returns all state to its reset values. Partial-bag history is lost.

## Structure
- Shared package tetris_pkg holds:
  - PIECE_W and NUM_TYPES defaults.
  - PIECE_NONE = all-ones.
  - piece_t typedef, logic [PIECE_W-1:0].
- Sub-module piece_fifo:
  - Circular buffer of DEPTH entries with head/tail pointers and a level counter.
  - push/pop inputs and the PREVIEW tap outputs.
  - Pointer wrap is modulo DEPTH; DEPTH need not be a power of two.
- The top level holds taken[], the bag total, the accept logic and bag_done.

## Test plan
- Reset then candidates 0,1,2,3,4,5,6 back-to-back with pop_ready=0 -> all accepted; level=7; preview = 0,1,2,3,4 in slots 0..4; bag_done pulses once, the cycle after cand=6 is accepted.
- Candidates 3,3,7,5 at defaults -> second 3 rejected, code 7 rejected, 5 accepted; level=2.
- COPIES=2, candidate stream 0,0,0 -> exactly two 0s accepted; bag_done only after 14 accepts.
- DEPTH=8: fill to 8, then offer new-bag candidate 2 with pop_ready=1 in the same cycle -> accepted; level stays 8; old head leaves, 2 lands at the tail.
- With the FIFO empty, accept candidate 4 -> next cycle pop_valid=1 and pop_piece=4. Pop it -> pop_valid=0 and pop_piece=all-ones.
- clear asserted mid-bag after 3 accepts -> level=0 next cycle, no bag_done; those 3 codes are accepted again afterwards.
